// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage SRAM controller.
//   state_t       FSM states IDLE, LO (low half), HI (high half), DONE
//   HALF_W        width of one SRAM data phase
//   DEF_BASE_ADDR default byte address of SRAM halfword 0
//   WAIT_CNT_W    width of the per-phase wait counter (WAIT_CYCLES 0..15)
//   half_sel()    picks the low or high 16-bit half of a 32-bit word
package mem_pkg;

   localparam int HALF_W        = 16;
   localparam int DEF_BASE_ADDR = 1024;
   localparam int WAIT_CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [HALF_W-1:0] half_sel(input logic [2*HALF_W-1:0] w,
                                                  input logic                 hi);
      logic [HALF_W-1:0] r;
      if (hi) begin
         r = w[2*HALF_W-1:HALF_W];
      end else begin
         r = w[HALF_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_timer.sv
// sram_wait_timer: per-phase cycle counter for the SRAM controller.
// Counts 0..WAIT_CYCLES and then holds; load restarts it at 0.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous reset, active-low
//   load    in  restart the count at 0 on the next edge
//   is_last out current cycle is the final cycle of the phase
module sram_wait_timer
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic is_last
);

   logic [WAIT_CNT_W-1:0] count_r;

   assign is_last = (count_r == WAIT_CNT_W'(WAIT_CYCLES));

   // Phase counter: restart on load, otherwise advance until the last cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_r <= {WAIT_CNT_W{1'b0}};
      end else if (load) begin
         count_r <= {WAIT_CNT_W{1'b0}};
      end else if (!is_last) begin
         count_r <= count_r + WAIT_CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage controller doing each 32-bit load/store as
// two 16-bit phases (low half at even, high half at odd halfword address) on
// an SRAM-style port, holding ready low until the access retires.
// Optional macro MEM_RANGE_CHECK_EN: out-of-range requests skip the SRAM,
// reads return 0 and addr_err latches until reset. Without it addresses wrap.
// Ports:
//   clk, rst (sync, active-low)
//   mem_r_en, mem_w_en  load/store request (both set = store)
//   alu_result          byte address, st_val store data
//   mem_result          load data, valid in DONE
//   ready               0 = freeze pipeline
//   sram_addr, sram_dq_out, sram_dq_in, sram_we_n, sram_oe_n  SRAM port
//   addr_err            sticky range error (0 without the macro)
module mem_stage_sram_ctrl
   import mem_pkg::*;
#(
   parameter int BIT_NUMBER  = 32,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 1,
   parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_r_en,
   input  logic                   mem_w_en,
   input  logic [BIT_NUMBER-1:0]  alu_result,
   input  logic [BIT_NUMBER-1:0]  st_val,
   output logic [BIT_NUMBER-1:0]  mem_result,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [HALF_W-1:0]      sram_dq_out,
   input  logic [HALF_W-1:0]      sram_dq_in,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   output logic                   addr_err
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] LO   = ST_LO;
   localparam logic [1:0] HI   = ST_HI;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]             state_r;
   logic [SRAM_ADDR_W-2:0] word_r;
   logic [HALF_W-1:0]      hi_data_r;
   logic                   wr_r;
   logic [BIT_NUMBER-1:0]  mem_result_r;
   logic [SRAM_ADDR_W-1:0] sram_addr_r;
   logic [HALF_W-1:0]      sram_dq_out_r;
   logic                   sram_we_n_r;
   logic                   sram_oe_n_r;

   logic                   req_s;
   logic [BIT_NUMBER-1:0]  off_s;
   logic [SRAM_ADDR_W-2:0] word_s;
   logic                   ready_s;
   logic                   tload_s;
   logic                   last_s;
   logic                   unused_s;

   assign req_s  = mem_r_en | mem_w_en;
   assign off_s  = alu_result - BIT_NUMBER'(BASE_ADDR);
   assign word_s = off_s[SRAM_ADDR_W:2];

`ifdef MEM_RANGE_CHECK_EN
   logic addr_err_r;
   logic oor_s;
   // Below the base, or beyond the last SRAM byte, is out of range.
   assign oor_s    = (alu_result < BIT_NUMBER'(BASE_ADDR)) |
                     (|off_s[BIT_NUMBER-1:SRAM_ADDR_W+1]);
   assign addr_err = addr_err_r;
   assign unused_s = ^off_s[1:0];
`else
   // Upper offset bits are dropped: the address wraps modulo SRAM size.
   assign addr_err = 1'b0;
   assign unused_s = ^{off_s[1:0], off_s[BIT_NUMBER-1:SRAM_ADDR_W+1]};
`endif

   sram_wait_timer #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tload_s),
      .is_last(last_s)
   );

   // Pipeline handshake and phase-timer restart derived from the state.
   always_comb begin
      ready_s = 1'b0;
      tload_s = 1'b1;
      case (state_r)
         IDLE: begin
            ready_s = ~req_s;
            tload_s = 1'b1;
         end
         LO, HI: begin
            ready_s = 1'b0;
            tload_s = last_s;
         end
         DONE: begin
            ready_s = 1'b1;
            tload_s = 1'b1;
         end
         default: begin
            ready_s = 1'b0;
            tload_s = 1'b1;
         end
      endcase
   end

   assign ready       = ready_s;
   assign mem_result  = mem_result_r;
   assign sram_addr   = sram_addr_r;
   assign sram_dq_out = sram_dq_out_r;
   assign sram_we_n   = sram_we_n_r;
   assign sram_oe_n   = sram_oe_n_r;

   // Access FSM; SRAM outputs are loaded on the edge entering each phase.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         word_r        <= {(SRAM_ADDR_W-1){1'b0}};
         hi_data_r     <= {HALF_W{1'b0}};
         wr_r          <= 1'b0;
         mem_result_r  <= {BIT_NUMBER{1'b0}};
         sram_addr_r   <= {SRAM_ADDR_W{1'b0}};
         sram_dq_out_r <= {HALF_W{1'b0}};
         sram_we_n_r   <= 1'b1;
         sram_oe_n_r   <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
         addr_err_r    <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s) begin
`ifdef MEM_RANGE_CHECK_EN
                  if (oor_s) begin
                     // Skip the SRAM entirely; a read retires with zero data.
                     state_r    <= DONE;
                     addr_err_r <= 1'b1;
                     if (!mem_w_en) begin
                        mem_result_r <= {BIT_NUMBER{1'b0}};
                     end else begin
                        mem_result_r <= mem_result_r;
                     end
                  end else begin
`endif
                     state_r       <= LO;
                     word_r        <= word_s;
                     hi_data_r     <= half_sel(st_val, 1'b1);
                     wr_r          <= mem_w_en;
                     sram_addr_r   <= {word_s, 1'b0};
                     sram_dq_out_r <= mem_w_en ? half_sel(st_val, 1'b0) : sram_dq_out_r;
                     sram_we_n_r   <= ~mem_w_en;
                     sram_oe_n_r   <= mem_w_en;
`ifdef MEM_RANGE_CHECK_EN
                  end
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            LO: begin
               if (last_s) begin
                  state_r     <= HI;
                  sram_addr_r <= {word_r, 1'b1};
                  if (wr_r) begin
                     sram_dq_out_r <= hi_data_r;
                  end else begin
                     mem_result_r[HALF_W-1:0] <= sram_dq_in;
                  end
               end else begin
                  state_r <= LO;
               end
            end
            HI: begin
               if (last_s) begin
                  state_r     <= DONE;
                  sram_we_n_r <= 1'b1;
                  sram_oe_n_r <= 1'b1;
                  if (!wr_r) begin
                     mem_result_r[2*HALF_W-1:HALF_W] <= sram_dq_in;
                  end else begin
                     mem_result_r <= mem_result_r;
                  end
               end else begin
                  state_r <= HI;
               end
            end
            DONE: begin
               // The request still visible here is the one retiring now.
               state_r <= IDLE;
            end
            default: begin
               state_r     <= IDLE;
               sram_we_n_r <= 1'b1;
               sram_oe_n_r <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: an SRAM array model on the
// port, and a word-level reference memory predicting load data, latency and
// strobe counts from the address map and timing rules.
module tb_mem_stage_sram_ctrl;

   localparam int W    = 1;
   localparam int BASE = 1024;
   localparam int PH   = W + 1;
   localparam int LAT  = 2 * PH + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] alu_result, st_val;
   logic [31:0] mem_result;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_we_n, sram_oe_n, addr_err;

   logic [15:0] sram_mem [0:262143];
   logic [33:0] wlog [$];
   int          cyc = 0;
   int          we_total = 0;
   int          oe_total = 0;
   int          passed = 0;
   int          total = 0;
   logic [31:0] model_mem [int];

   mem_stage_sram_ctrl #(
      .BIT_NUMBER(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_result(alu_result), .st_val(st_val), .mem_result(mem_result),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

   // SRAM model plus strobe bookkeeping.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!sram_we_n) begin
         sram_mem[sram_addr] = sram_dq_out;
         wlog.push_back({sram_addr, sram_dq_out});
         we_total = we_total + 1;
      end
      if (!sram_oe_n) oe_total = oe_total + 1;
   end

   // Word index a byte address selects (wrapping modulo SRAM words).
   function automatic int widx(input logic [31:0] a);
      logic [31:0] o;
      o = (a - 32'(BASE)) / 32'd4;
      return int'(o % 32'd131072);
   endfunction

   // Issue one access at posedge+1 and follow it until ready is seen.
   task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, output int low, output logic [31:0] res,
                             output int start_c, output int done_c, output int we_c,
                             output int oe_c, output int wl0, output logic to);
      int we0, oe0;
      we0 = we_total; oe0 = oe_total; wl0 = wlog.size();
      mem_w_en = wr; mem_r_en = rd; alu_result = a; st_val = d;
      start_c = cyc; done_c = 0; low = 0; res = 32'h0; to = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            res = mem_result; done_c = cyc; to = 1'b0;
            break;
         end
         low++;
      end
      @(posedge clk); #1;
      mem_w_en = 1'b0; mem_r_en = 1'b0;
      we_c = we_total - we0; oe_c = oe_total - oe0;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = 32'h0; st_val = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if ({ready, sram_we_n, sram_oe_n} !== 3'b111) $display("FAIL reset_strobes got %b want 111", {ready, sram_we_n, sram_oe_n}); else passed++;
      total++; if (mem_result !== 32'h0) $display("FAIL reset_result got %h want 0", mem_result); else passed++;
      total++; if ({sram_addr, sram_dq_out} !== 34'h0) $display("FAIL reset_port got %h/%h want 0/0", sram_addr, sram_dq_out); else passed++;
      total++; if (addr_err !== 1'b0) $display("FAIL reset_err got %b want 0", addr_err); else passed++;
      @(posedge clk); #1; rst = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++; if ({ready, sram_we_n, sram_oe_n} !== 3'b111) $display("FAIL idle_%0d got %b want 111", i, {ready, sram_we_n, sram_oe_n}); else passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      int low, sc, dc, wc, oc, wl0; logic [31:0] res; logic to;
      logic [33:0] e; logic [17:0] ea; logic [15:0] ed;
      run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, low, res, sc, dc, wc, oc, wl0, to);
      model_mem[widx(32'd1028)] = 32'hDEADBEEF;
      total++; if (to !== 1'b0 || low != LAT) $display("FAIL store_lat got %0d want %0d (timeout %b)", low, LAT, to); else passed++;
      total++; if (wc != 2 * PH || oc != 0) $display("FAIL store_strobes got we=%0d oe=%0d want %0d/0", wc, oc, 2 * PH); else passed++;
      for (int i = 0; i < 2 * PH; i++) begin
         ea = (i < PH) ? 18'd2 : 18'd3;
         ed = (i < PH) ? 16'hBEEF : 16'hDEAD;
         e = (wl0 + i < wlog.size()) ? wlog[wl0 + i] : 34'h0;
         total++; if (e !== {ea, ed}) $display("FAIL store_phase_%0d got %h/%h want %h/%h", i, e[33:16], e[15:0], ea, ed); else passed++;
      end
   endtask

   task automatic test_load();
      int low, sc, dc, wc, oc, wl0; logic [31:0] res; logic to;
      run_access(1'b0, 1'b1, 32'd1028, 32'h0, low, res, sc, dc, wc, oc, wl0, to);
      total++; if (to !== 1'b0 || res !== model_mem[widx(32'd1028)]) $display("FAIL load_data got %h want %h", res, model_mem[widx(32'd1028)]); else passed++;
      total++; if (low != LAT) $display("FAIL load_lat got %0d want %0d", low, LAT); else passed++;
      total++; if (oc != 2 * PH || wc != 0) $display("FAIL load_strobes got oe=%0d we=%0d want %0d/0", oc, wc, 2 * PH); else passed++;
   endtask

   task automatic test_back_to_back();
      int low, sc, dc, wc, oc, wl0, low2, sc2, dc2, wc2, oc2; logic [31:0] res, d1, d2; logic to, to2;
      d1 = $urandom(); d2 = $urandom();
      run_access(1'b1, 1'b0, 32'd1032, d1, low, res, sc, dc, wc, oc, wl0, to);
      model_mem[widx(32'd1032)] = d1;
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 32'd1028, d2, low, res, sc, dc, wc, oc, wl0, to);
      model_mem[widx(32'd1028)] = d2;
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, low2, res, sc2, dc2, wc2, oc2, wl0, to2);
      total++; if (to !== 1'b0 || wc != 2 * PH) $display("FAIL b2b_store_we got %0d want %0d", wc, 2 * PH); else passed++;
      total++; if (sc2 != dc + 1) $display("FAIL b2b_start got %0d want %0d", sc2, dc + 1); else passed++;
      total++; if (to2 !== 1'b0 || low2 != LAT) $display("FAIL b2b_lat got %0d want %0d", low2, LAT); else passed++;
      total++; if (oc2 != 2 * PH || wc2 != 0) $display("FAIL b2b_load_strobes got oe=%0d we=%0d want %0d/0", oc2, wc2, 2 * PH); else passed++;
      total++; if (res !== d1) $display("FAIL b2b_data got %h want %h", res, d1); else passed++;
      run_access(1'b0, 1'b1, 32'd1028, 32'h0, low2, res, sc2, dc2, wc2, oc2, wl0, to2);
      total++; if (res !== d2) $display("FAIL b2b_data2 got %h want %h", res, d2); else passed++;
   endtask

   task automatic test_reset_mid();
      int low, sc, dc, wc, oc, wl0, n0; logic [31:0] res; logic to;
      run_access(1'b1, 1'b0, 32'd1040, 32'h11112222, low, res, sc, dc, wc, oc, wl0, to);
      mem_w_en = 1'b1; alu_result = 32'd1040; st_val = 32'hAAAABBBB;
      repeat (3) @(posedge clk); #1;
      total++; if ({sram_we_n, sram_addr} !== {1'b0, 18'd9}) $display("FAIL rmid_in_hi got %b/%0d want 0/9", sram_we_n, sram_addr); else passed++;
      rst = 1'b0; mem_w_en = 1'b0;
      @(posedge clk); #1;
      n0 = wlog.size();
      total++; if ({ready, sram_we_n, sram_oe_n} !== 3'b111) $display("FAIL rmid_strobes got %b want 111", {ready, sram_we_n, sram_oe_n}); else passed++;
      total++; if (sram_addr !== 18'd0 || mem_result !== 32'h0) $display("FAIL rmid_regs got %h/%h want 0/0", sram_addr, mem_result); else passed++;
      rst = 1'b1;
      repeat (5) @(posedge clk); #1;
      total++; if (wlog.size() != n0) $display("FAIL rmid_no_write got %0d want %0d", wlog.size(), n0); else passed++;
      model_mem.delete(widx(32'd1040));
   endtask

   task automatic test_random();
      int low, sc, dc, wc, oc, wl0, k, op; logic [31:0] res, a, d; logic to;
      for (int i = 0; i < 16; i++) begin
         d = $urandom();
         run_access(1'b1, 1'b0, 32'(BASE + 4 * i), d, low, res, sc, dc, wc, oc, wl0, to);
         model_mem[i] = d;
      end
      for (int n = 0; n < 40; n++) begin
         k = int'($urandom_range(15, 0)); op = int'($urandom_range(2, 0));
         a = 32'(BASE + 4 * k) + 32'($urandom_range(3, 0)); d = $urandom();
         run_access(op != 0, op != 1, a, d, low, res, sc, dc, wc, oc, wl0, to);
         total++; if (to !== 1'b0 || low != LAT) $display("FAIL rnd_lat_%0d got %0d want %0d", n, low, LAT); else passed++;
         if (op == 0) begin
            total++; if (res !== model_mem[k] || oc != 2 * PH || wc != 0) $display("FAIL rnd_load_%0d got %h oe=%0d want %h oe=%0d", n, res, oc, model_mem[k], 2 * PH); else passed++;
         end else begin
            model_mem[k] = d;
            total++; if (wc != 2 * PH || oc != 0) $display("FAIL rnd_store_%0d got we=%0d oe=%0d want %0d/0", n, wc, oc, 2 * PH); else passed++;
         end
         repeat ($urandom_range(2, 0)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_range();
      int low, sc, dc, wc, oc, wl0; logic [31:0] res, d; logic to;
`ifdef MEM_RANGE_CHECK_EN
      run_access(1'b0, 1'b1, 32'd512, 32'h0, low, res, sc, dc, wc, oc, wl0, to);
      total++; if (to !== 1'b0 || low != 1) $display("FAIL oor_lat got %0d want 1", low); else passed++;
      total++; if (res !== 32'h0 || wc + oc != 0) $display("FAIL oor_read got %h strobes=%0d want 0/0", res, wc + oc); else passed++;
      total++; if (addr_err !== 1'b1) $display("FAIL oor_err got %b want 1", addr_err); else passed++;
      run_access(1'b1, 1'b0, 32'(BASE + (1 << 19)), 32'h12345678, low, res, sc, dc, wc, oc, wl0, to);
      total++; if (low != 1 || wc != 0) $display("FAIL oor_high got lat=%0d we=%0d want 1/0", low, wc); else passed++;
      run_access(1'b0, 1'b1, 32'd1028, 32'h0, low, res, sc, dc, wc, oc, wl0, to);
      total++; if (res !== model_mem[1] || addr_err !== 1'b1) $display("FAIL oor_sticky got %h/%b want %h/1", res, addr_err, model_mem[1]); else passed++;
`else
      d = $urandom();
      run_access(1'b1, 1'b0, 32'(BASE + (1 << 19) + 8), d, low, res, sc, dc, wc, oc, wl0, to);
      model_mem[widx(32'(BASE + (1 << 19) + 8))] = d;
      total++; if (wlog.size() <= wl0 || wlog[wl0][33:16] !== 18'd4) $display("FAIL wrap_addr got %0d want 4", (wlog.size() > wl0) ? wlog[wl0][33:16] : 18'h3FFFF); else passed++;
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, low, res, sc, dc, wc, oc, wl0, to);
      total++; if (res !== model_mem[widx(32'd1032)]) $display("FAIL wrap_data got %h want %h", res, model_mem[widx(32'd1032)]); else passed++;
      total++; if (addr_err !== 1'b0) $display("FAIL wrap_err got %b want 0", addr_err); else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_idle();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_range();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
